// File: rtl/yarp_decode_stage_pkg.sv
// Shared decode-stage types: opcode constants, one-hot instruction class,
// decoded bundle and the immediate generator.
package yarp_pkg;

   localparam logic [6:0] R_TYPE  = 7'b0110011;
   localparam logic [6:0] I_LOAD  = 7'b0000011;
   localparam logic [6:0] I_ALU   = 7'b0010011;
   localparam logic [6:0] I_JALR  = 7'b1100111;
   localparam logic [6:0] S_TYPE  = 7'b0100011;
   localparam logic [6:0] B_TYPE  = 7'b1100011;
   localparam logic [6:0] U_LUI   = 7'b0110111;
   localparam logic [6:0] U_AUIPC = 7'b0010111;
   localparam logic [6:0] J_TYPE  = 7'b1101111;

   // imm is carried at the widest supported XLEN; bits above XLEN are sign copies.
   localparam int IMM_W = 64;

   // One-hot {r,i,s,b,u,j}; T_NONE marks an illegal beat.
   typedef enum logic [5:0] {
      T_NONE = 6'b000000,
      T_J    = 6'b000001,
      T_U    = 6'b000010,
      T_B    = 6'b000100,
      T_S    = 6'b001000,
      T_I    = 6'b010000,
      T_R    = 6'b100000
   } instr_type_e;

   typedef struct packed {
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [6:0]       op;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      instr_type_e      itype;
      logic [IMM_W-1:0] imm;
   } decode_bundle_t;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   function automatic logic [IMM_W-1:0] dec_imm(input logic [31:0] instr, input instr_type_e t);
      logic [IMM_W-1:0] imm;
      imm = '0;
      case (t)
         T_I: imm = {{52{instr[31]}}, instr[31:20]};
         T_S: imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         T_B: imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         T_U: imm = {{32{instr[31]}}, instr[31:12], 12'b0};
         T_J: imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/yarp_decode_stage_if.sv
// Fetch-in / execute-out bundle of the decode stage.
interface yarp_decode_stage_if
   import yarp_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) ();
   localparam int CW = (CNT_W > 0) ? CNT_W : 1;

   logic             in_valid_i;
   logic             in_ready_o;
   logic [XLEN-1:0]  in_pc_i;
   logic [31:0]      in_instr_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [XLEN-1:0]  out_pc_o;
   decode_bundle_t   out_dec_o;
   logic             out_illegal_o;
   logic [CW-1:0]    dec_count_o;

   modport master (
      output in_valid_i, in_pc_i, in_instr_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_pc_o, out_dec_o, out_illegal_o, dec_count_o
   );

   modport slave (
      input  in_valid_i, in_pc_i, in_instr_i, out_ready_i,
      output in_ready_o, out_valid_o, out_pc_o, out_dec_o, out_illegal_o, dec_count_o
   );
endinterface

// File: rtl/yarp_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready depends only on the
// state register, so there is no combinational ready path through it.
module yarp_skid_buf
   import yarp_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   skid_state_e  state, state_nxt;
   logic [W-1:0] m_q, s_q;
   logic         in_xfer, out_xfer, m_ld_in, m_ld_s, s_ld;

   assign in_ready  = (state != SKID_FULL);
   assign out_valid = (state != SKID_EMPTY);
   assign out_data  = m_q;
   assign in_xfer   = in_valid & in_ready & ~flush;
   assign out_xfer  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SKID_EMPTY;
         m_q   <= '0;
         s_q   <= '0;
      end else begin
         state <= state_nxt;
         if (m_ld_in)   m_q <= in_data;
         else if (m_ld_s) m_q <= s_q;
         if (s_ld)      s_q <= in_data;
      end
   end

   always_comb begin
      state_nxt = state;
      m_ld_in   = 1'b0;
      m_ld_s    = 1'b0;
      s_ld      = 1'b0;
      case (state)
         SKID_EMPTY: if (in_xfer) begin
            state_nxt = SKID_ONE;
            m_ld_in   = 1'b1;
         end
         SKID_ONE: begin
            if (in_xfer && out_xfer) m_ld_in = 1'b1;
            else if (out_xfer)       state_nxt = SKID_EMPTY;
            else if (in_xfer) begin
               s_ld      = 1'b1;
               state_nxt = SKID_FULL;
            end
         end
         SKID_FULL: if (out_xfer) begin
            m_ld_s    = 1'b1;
            state_nxt = SKID_ONE;
         end
         default: state_nxt = SKID_EMPTY;
      endcase
      // Flush discards everything still buffered; an out transfer this cycle still happened.
      if (flush) begin
         state_nxt = SKID_EMPTY;
         m_ld_s    = 1'b0;
      end
   end

endmodule

// File: rtl/yarp_decode_stage.sv
// Registered RV32 decode stage: combinational decode of the fetch beat,
// captured into a skid buffer, plus an optional handed-off beat counter.
module yarp_decode_stage
   import yarp_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit EN_M_EXT = 1'b0,
   parameter int CNT_W    = 32
) (
   input  logic clk,
   input  logic reset_n,
   input  logic flush_i,
   yarp_decode_stage_if.slave bus
);
   localparam int PW = 1 + XLEN + $bits(decode_bundle_t);

   decode_bundle_t dec;
   instr_type_e    t;
   logic           illegal;
   logic [6:0]     op, f7;
   logic [2:0]     f3;
   logic [PW-1:0]  out_data;

   assign op = bus.in_instr_i[6:0];
   assign f3 = bus.in_instr_i[14:12];
   assign f7 = bus.in_instr_i[31:25];

   always_comb begin
      t       = T_NONE;
      illegal = 1'b0;
      case (op)
         R_TYPE: begin
            t = T_R;
            if (!(f7 == 7'h00 || f7 == 7'h20 || (EN_M_EXT && f7 == 7'h01))) illegal = 1'b1;
            if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) illegal = 1'b1;
         end
         I_LOAD: t = T_I;
         I_ALU: begin
            t = T_I;
            // Shift-immediate encodings reuse imm[11:5] as funct7.
            if (f3 == 3'b001 && f7 != 7'h00) illegal = 1'b1;
            if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
         end
         I_JALR: begin
            t = T_I;
            if (f3 != 3'b000) illegal = 1'b1;
         end
         S_TYPE: t = T_S;
         B_TYPE: begin
            t = T_B;
            if (f3 == 3'b010 || f3 == 3'b011) illegal = 1'b1;
         end
         U_LUI, U_AUIPC: t = T_U;
         J_TYPE: t = T_J;
         default: illegal = 1'b1;
      endcase
      if (bus.in_instr_i[1:0] != 2'b11) illegal = 1'b1;
      if (illegal) t = T_NONE;

      dec        = '0;
      dec.rs1    = bus.in_instr_i[19:15];
      dec.rs2    = bus.in_instr_i[24:20];
      dec.rd     = bus.in_instr_i[11:7];
      dec.op     = op;
      dec.funct3 = f3;
      dec.funct7 = f7;
      dec.itype  = t;
      dec.imm    = illegal ? '0 : dec_imm(bus.in_instr_i, t);
   end

   yarp_skid_buf #(.W(PW)) u_skid (
      .clk       (clk),
      .rst_n     (reset_n),
      .flush     (flush_i),
      .in_valid  (bus.in_valid_i),
      .in_ready  (bus.in_ready_o),
      .in_data   ({illegal, bus.in_pc_i, dec}),
      .out_valid (bus.out_valid_o),
      .out_ready (bus.out_ready_i),
      .out_data  (out_data)
   );

   assign {bus.out_illegal_o, bus.out_pc_o, bus.out_dec_o} = out_data;

   generate
      if (CNT_W > 0) begin : g_cnt
         localparam logic [CNT_W-1:0] CNT_ONE = 1;
         logic [CNT_W-1:0] cnt;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)                               cnt <= '0;
            else if (bus.out_valid_o && bus.out_ready_i) cnt <= cnt + CNT_ONE;
         end
         assign bus.dec_count_o = cnt;
      end else begin : g_no_cnt
         assign bus.dec_count_o = '0;
      end
   endgenerate

endmodule

// File: tb/tb_yarp_decode_stage.sv
// Directed bench: a 32-bit/M-off stage and a 64-bit/M-on/no-counter stage
// are driven with the same beats and checked against hand-decoded values.
module tb_yarp_decode_stage;
   import yarp_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic        out_ready = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_cnt = '0;

   always #5 clk = ~clk;

   yarp_decode_stage_if #(.XLEN(32), .CNT_W(32)) bus32 ();
   yarp_decode_stage_if #(.XLEN(64), .CNT_W(0))  bus64 ();

   assign bus32.in_valid_i  = in_valid;
   assign bus32.in_pc_i     = in_pc;
   assign bus32.in_instr_i  = in_instr;
   assign bus32.out_ready_i = out_ready;
   assign bus64.in_valid_i  = in_valid;
   assign bus64.in_pc_i     = {32'h0, in_pc};
   assign bus64.in_instr_i  = in_instr;
   assign bus64.out_ready_i = out_ready;

   yarp_decode_stage #(.XLEN(32), .EN_M_EXT(1'b0), .CNT_W(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .flush_i(flush), .bus(bus32.slave));
   yarp_decode_stage #(.XLEN(64), .EN_M_EXT(1'b1), .CNT_W(0)) dut64 (
      .clk(clk), .reset_n(reset_n), .flush_i(flush), .bus(bus64.slave));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (bus32.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus32.out_valid_o); end
      checks++; if (bus32.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", bus32.in_ready_o); end
      checks++; if (bus32.dec_count_o !== 32'd0) begin errors++; $display("FAIL reset_count got %0h exp 0", bus32.dec_count_o); end
      checks++; if ({bus32.out_pc_o, bus32.out_dec_o} !== '0) begin errors++; $display("FAIL reset_payload got %0h exp 0", {bus32.out_pc_o, bus32.out_dec_o}); end
      @(negedge clk) reset_n = 1'b1;
      step();
   endtask

   task automatic test_addi();
      out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h00500093;
      step();
      in_valid = 1'b0;
      checks++; if (bus32.out_valid_o !== 1'b1) begin errors++; $display("FAIL addi_latency got %0b exp 1", bus32.out_valid_o); end
      checks++; if (bus32.out_dec_o.itype !== T_I) begin errors++; $display("FAIL addi_type got %0h exp %0h", bus32.out_dec_o.itype, T_I); end
      checks++; if ({bus32.out_dec_o.rd, bus32.out_dec_o.rs1} !== {5'd1, 5'd0}) begin errors++; $display("FAIL addi_regs got rd=%0d rs1=%0d exp 1 0", bus32.out_dec_o.rd, bus32.out_dec_o.rs1); end
      checks++; if (bus32.out_dec_o.imm[31:0] !== 32'h5) begin errors++; $display("FAIL addi_imm got %0h exp 5", bus32.out_dec_o.imm[31:0]); end
      checks++; if (bus32.out_illegal_o !== 1'b0 || bus32.out_pc_o !== 32'h100) begin errors++; $display("FAIL addi_ill_pc got %0b %0h exp 0 100", bus32.out_illegal_o, bus32.out_pc_o); end
      step(); exp_cnt++;
      checks++; if (bus32.dec_count_o !== exp_cnt || bus32.out_valid_o !== 1'b0) begin errors++; $display("FAIL addi_count got %0d/%0b exp %0d/0", bus32.dec_count_o, bus32.out_valid_o, exp_cnt); end
   endtask

   task automatic test_store_branch();
      out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h104; in_instr = 32'hFE112E23;
      step();
      in_pc = 32'h108; in_instr = 32'hFE000CE3;
      checks++; if (bus32.out_dec_o.itype !== T_S || bus32.out_dec_o.rs1 !== 5'd2 || bus32.out_dec_o.rs2 !== 5'd1) begin errors++; $display("FAIL sw_fields got t=%0h rs1=%0d rs2=%0d exp 08 2 1", bus32.out_dec_o.itype, bus32.out_dec_o.rs1, bus32.out_dec_o.rs2); end
      checks++; if (bus32.out_dec_o.imm[31:0] !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_imm got %0h exp fffffffc", bus32.out_dec_o.imm[31:0]); end
      checks++; if (bus64.out_dec_o.imm !== 64'hFFFFFFFFFFFFFFFC) begin errors++; $display("FAIL sw_imm64 got %0h exp fffffffffffffffc", bus64.out_dec_o.imm); end
      step(); exp_cnt++;
      in_valid = 1'b0;
      checks++; if (bus32.out_dec_o.itype !== T_B || bus32.out_pc_o !== 32'h108) begin errors++; $display("FAIL beq_type got %0h pc %0h exp 04 108", bus32.out_dec_o.itype, bus32.out_pc_o); end
      checks++; if (bus32.out_dec_o.imm[31:0] !== 32'hFFFFFFF8) begin errors++; $display("FAIL beq_imm got %0h exp fffffff8", bus32.out_dec_o.imm[31:0]); end
      step(); exp_cnt++;
      checks++; if (bus32.dec_count_o !== exp_cnt) begin errors++; $display("FAIL sb_count got %0d exp %0d", bus32.dec_count_o, exp_cnt); end
   endtask

   task automatic test_lui();
      out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h10C; in_instr = 32'h123452B7;
      step();
      in_valid = 1'b0;
      checks++; if (bus32.out_dec_o.itype !== T_U || bus32.out_dec_o.rd !== 5'd5) begin errors++; $display("FAIL lui_fields got t=%0h rd=%0d exp 02 5", bus32.out_dec_o.itype, bus32.out_dec_o.rd); end
      checks++; if (bus32.out_dec_o.imm[31:0] !== 32'h12345000) begin errors++; $display("FAIL lui_imm got %0h exp 12345000", bus32.out_dec_o.imm[31:0]); end
      checks++; if (bus64.out_dec_o.imm !== 64'h0000000012345000) begin errors++; $display("FAIL lui_imm64 got %0h exp 12345000", bus64.out_dec_o.imm); end
      step(); exp_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] b0, b1;
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
      in_pc = 32'h200; step();
      checks++; if (bus32.in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %0b exp 1", bus32.in_ready_o); end
      in_pc = 32'h204; step();
      checks++; if (bus32.in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready2 got %0b exp 0", bus32.in_ready_o); end
      in_pc = 32'h208; step();
      checks++; if (bus32.in_ready_o !== 1'b0 || bus32.out_pc_o !== 32'h200) begin errors++; $display("FAIL bp_hold got %0b %0h exp 0 200", bus32.in_ready_o, bus32.out_pc_o); end
      out_ready = 1'b1;
      step(); exp_cnt++;
      b0 = bus32.out_pc_o;
      step(); exp_cnt++;
      b1 = bus32.out_pc_o;
      in_valid = 1'b0;
      checks++; if (b0 !== 32'h204 || b1 !== 32'h208) begin errors++; $display("FAIL bp_order got %0h %0h exp 204 208", b0, b1); end
      checks++; if (bus32.out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_nobubble got %0b exp 1", bus32.out_valid_o); end
      step(); exp_cnt++;
      checks++; if (bus32.dec_count_o !== exp_cnt || bus32.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_count got %0d/%0b exp %0d/0", bus32.dec_count_o, bus32.out_valid_o, exp_cnt); end
   endtask

   task automatic test_illegal();
      logic [31:0] vec_i [5] = '{32'h0000007F, 32'h02208033, 32'h40001093, 32'h40005093, 32'h00001067};
      logic        ill32 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic        ill64 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_instr = vec_i[k]; in_pc = 32'h300 + 32'(k * 4);
         step();
         in_valid = 1'b0;
         checks++; if (bus32.out_illegal_o !== ill32[k] || bus64.out_illegal_o !== ill64[k]) begin errors++; $display("FAIL ill_%0d got %0b/%0b exp %0b/%0b", k, bus32.out_illegal_o, bus64.out_illegal_o, ill32[k], ill64[k]); end
         if (ill32[k]) begin
            checks++; if (bus32.out_dec_o.itype !== T_NONE || bus32.out_dec_o.imm !== '0) begin errors++; $display("FAIL ill_clear_%0d got t=%0h imm=%0h exp 0 0", k, bus32.out_dec_o.itype, bus32.out_dec_o.imm); end
         end
         if (k == 1) begin
            checks++; if (bus64.out_dec_o.itype !== T_R || bus64.out_dec_o.rs1 !== 5'd1 || bus64.out_dec_o.rs2 !== 5'd2) begin errors++; $display("FAIL mext_fields got t=%0h rs1=%0d rs2=%0d exp 20 1 2", bus64.out_dec_o.itype, bus64.out_dec_o.rs1, bus64.out_dec_o.rs2); end
         end
         step(); exp_cnt++;
      end
      checks++; if (bus32.dec_count_o !== exp_cnt || bus64.dec_count_o !== 1'b0) begin errors++; $display("FAIL ill_count got %0d/%0b exp %0d/0", bus32.dec_count_o, bus64.dec_count_o, exp_cnt); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
      in_pc = 32'h400; step();
      in_pc = 32'h404; step();
      in_pc = 32'h408; flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (bus32.out_valid_o !== 1'b0 || bus32.in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_state got %0b/%0b exp 0/1", bus32.out_valid_o, bus32.in_ready_o); end
      checks++; if (bus32.dec_count_o !== exp_cnt) begin errors++; $display("FAIL flush_count got %0d exp %0d", bus32.dec_count_o, exp_cnt); end
      out_ready = 1'b1; step();
      checks++; if (bus32.out_valid_o !== 1'b0 || bus32.dec_count_o !== exp_cnt) begin errors++; $display("FAIL flush_drop got %0b/%0d exp 0/%0d", bus32.out_valid_o, bus32.dec_count_o, exp_cnt); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h123452B7;
      in_pc = 32'h500; step();
      in_pc = 32'h504; step();
      in_valid = 1'b0;
      reset_n = 1'b0; #1;
      exp_cnt = '0;
      checks++; if (bus32.out_valid_o !== 1'b0 || bus32.in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_state got %0b/%0b exp 0/1", bus32.out_valid_o, bus32.in_ready_o); end
      checks++; if (bus32.dec_count_o !== exp_cnt || bus32.out_pc_o !== 32'h0 || bus32.out_dec_o !== '0) begin errors++; $display("FAIL rst_mid_regs got cnt=%0d pc=%0h exp 0 0", bus32.dec_count_o, bus32.out_pc_o); end
      @(negedge clk) reset_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_store_branch();
      test_lui();
      test_back_to_back();
      test_illegal();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/yarp_decode_stage.md
Name: yarp_decode_stage

Overview:
Registered, back-pressurable instruction-decode pipeline stage between fetch and execute. Accepts {pc, instr} beats over a valid/ready handshake. Decodes the opcode class, register indices, funct fields, the sign-extended immediate and an illegal-instruction flag. Presents the result one cycle later through a 2-entry skid buffer, so fetch never sees a combinational ready path from execute. Supports a pipeline flush and an optional decoded-instruction counter.

Parameters:
XLEN, 32, datapath/pc/immediate width (32 or 64); immediates sign-extend to XLEN.
EN_M_EXT, 0, 1: treat funct7=0x01 on OP opcode as legal (MUL/DIV class).
CNT_W, 32, width of decoded-instruction counter; 0 removes the counter.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush_i  in  1  drop all buffered and incoming beats
in_valid_i  in  1  fetch beat valid
in_ready_o  out  1  stage can accept a beat
in_pc_i  in  XLEN  pc of instruction
in_instr_i  in  32  raw instruction
out_valid_o  out  1  decoded beat valid
out_ready_i  in  1  execute accepts beat
out_pc_o  out  XLEN  pc of decoded beat
out_dec_o  out  $bits(decode_bundle_t)  rs1, rs2, rd, op, funct3, funct7, one-hot type {r,i,s,b,u,j}, imm[XLEN-1:0]
out_illegal_o  out  1  beat is an illegal instruction
dec_count_o  out  CNT_W  number of beats handed to execute since reset

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - out_valid_o=0, in_ready_o=1, dec_count_o=0, state EMPTY.
  - Payload registers reset to 0.
- Transfers: in on in_valid_i&in_ready_o; out on out_valid_o&out_ready_i.
- Decode is combinational on in_instr_i and is registered on the in transfer.
- Latency: exactly 1 cycle from in transfer to out_valid_o when the stage was empty.
- State machine (main reg M, skid reg S):
  - EMPTY: in_ready=1, out_valid=0. In transfer → ONE.
  - ONE: in_ready=1, out_valid=1.
    - In and out transfer together → M reloads, stay ONE.
    - Out transfer only → EMPTY.
    - In transfer only (out stalled) → new beat goes to S → FULL.
  - FULL: in_ready=0, out_valid=1, out shows M.
    - Out transfer → M←S, → ONE.
- in_ready_o is a registered function of state only. There is no combinational path from out_ready_i to in_ready_o.
- Ordering is strictly FIFO; no beat is duplicated or lost except by flush.
- Flush:
  - flush_i=1 forces state EMPTY next cycle and ignores any same-cycle in transfer.
  - out_valid_o stays as registered that cycle; execute must ignore it.
  - dec_count_o still counts an out transfer that completes in the flush cycle.
- Opcode classes:
  - R: 0110011.
  - I: 0000011, 0010011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Immediates:
  - I/S/B/J are sign-extended from instr[31] to XLEN.
  - U is instr[31:12]<<12, sign-extended to XLEN.
  - R gives imm=0.
- Illegal (out_illegal_o=1, type vector all zero, imm=0) when any of:
  - instr[1:0]≠11;
  - opcode not in the class list;
  - R with funct7 ∉ {0x00, 0x20, 0x01 if EN_M_EXT};
  - R with funct7=0x20 and funct3 ∉ {000, 101};
  - 0010011 with funct3=001 and funct7≠0x00;
  - 0010011 with funct3=101 and funct7 ∉ {0x00, 0x20} (XLEN=32 rule);
  - 1100111 with funct3≠000;
  - B with funct3 ∈ {010, 011}.
- Illegal beats flow through the handshake like any other beat.
- Counter: increments by 1 per out transfer and wraps at 2^CNT_W.
- Reset mid-transfer drops all state asynchronously.

Decomposition:
- yarp_pkg: opcode constants (existing R_TYPE…J_TYPE), decode_bundle_t packed struct, instr_type_e one-hot, function dec_imm(instr, type) returning the immediate.
- Sub-module yarp_skid_buf #(W): the generic 2-entry valid/ready skid buffer, holding the EMPTY/ONE/FULL state machine.
- Decode logic lives in yarp_decode_stage.

Test Plan:
- 0x00500093 (addi x1,x0,5), out_ready=1 → after 1 cycle: i type, rd=1, rs1=0, imm=0x00000005, illegal=0, count=1.
- 0xFE112E23 (sw x1,-4(x2)) → s type, rs1=2, rs2=1, imm=0xFFFFFFFC. Then 0xFE000CE3 (beq x0,x0,-8) → b type, imm=0xFFFFFFF8.
- 0x123452B7 (lui x5,0x12345) → u type, rd=5, imm=0x12345000. With XLEN=64 → imm=0x0000000012345000.
- Back-pressure: out_ready=0, push 3 beats → first two accepted, in_ready=0 after the second, third held. Release → beats emerge in order with no bubble and no loss; count=3.
- Illegal: 0x0000007F → illegal=1. 0x02208033 → illegal=1 with EN_M_EXT=0, legal r type with EN_M_EXT=1.
- Flush in FULL while in_valid=1 → next cycle out_valid=0, in_ready=1, incoming beat dropped, count unchanged. Also: reset_n low mid-stall → outputs return to reset values immediately.
